// File: rtl/sram_frame_arbiter.sv
// Double-buffered frame SRAM arbiter: VGA reads, background clear, program writes.
// Optional SRAM_ARB_OVERRUN_CNT_EN builds a saturating frame-overrun counter.
module sram_frame_arbiter #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480
) (
  input  logic        sram_clk,
  input  logic        reset,
  input  logic        frame_clk,
  input  logic        vga_req,
  input  logic [9:0]  vga_x,
  input  logic [9:0]  vga_y,
  output logic        vga_ack,
  output logic        vga_valid,
  output logic [15:0] vga_data,
  input  logic        prog_req,
  input  logic [9:0]  prog_x,
  input  logic [9:0]  prog_y,
  input  logic [15:0] prog_data,
  output logic        prog_ack,
  output logic [9:0]  bg_x,
  output logic [9:0]  bg_y,
  input  logic [15:0] background_data,
  output logic        draw_buf,
  output logic        clearing,
  output logic        SRAM_CE,
  output logic        SRAM_UB,
  output logic        SRAM_LB,
  output logic        SRAM_OE,
  output logic        SRAM_WE,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic [15:0] frame_overrun_cnt
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  localparam logic [9:0] HMAX = 10'(H_PIXELS);
  localparam logic [9:0] VMAX = 10'(V_PIXELS);

  state_e      state_q, state_d;
  logic        fs1_q, fs2_q, fs3_q;
  logic        draw_buf_q, draw_buf_d;
  logic        clearing_q, clearing_d;
  logic [9:0]  bg_x_q, bg_x_d;
  logic [9:0]  bg_y_q, bg_y_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        vga_ack_q, vga_ack_d;
  logic        prog_ack_q, prog_ack_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_oor_q, rd_oor_d;
  logic        vga_valid_q, vga_valid_d;
  logic [15:0] vga_data_q, vga_data_d;

  logic frame_rise;
  logic vga_go, clr_go, prog_go;
  logic vga_in, prog_in;

  assign frame_rise = fs2_q & ~fs3_q;
  assign vga_in  = (vga_x < HMAX) && (vga_y < VMAX);
  assign prog_in = (prog_x < HMAX) && (prog_y < VMAX);
  assign vga_go  = vga_req & ~vga_ack_q;
  assign clr_go  = clearing_q & ~vga_go;
  assign prog_go = prog_req & ~prog_ack_q & ~clearing_q & ~vga_go;

  always_comb begin
    state_d     = IDLE;
    draw_buf_d  = draw_buf_q;
    clearing_d  = clearing_q;
    bg_x_d      = bg_x_q;
    bg_y_d      = bg_y_q;
    ce_d        = 1'b1;
    oe_d        = 1'b1;
    we_d        = 1'b1;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    vga_ack_d   = 1'b0;
    prog_ack_d  = 1'b0;
    rd_pend_d   = 1'b0;
    rd_oor_d    = 1'b0;
    vga_valid_d = rd_pend_q;
    vga_data_d  = vga_data_q;
    if (rd_pend_q)
      vga_data_d = rd_oor_q ? 16'h0000 : SRAM_DQ;
    unique case (1'b1)
      vga_go: begin
        vga_ack_d = 1'b1;
        rd_pend_d = 1'b1;
        rd_oor_d  = ~vga_in;
        if (vga_in) begin
          state_d = READ;
          ce_d    = 1'b0;
          oe_d    = 1'b0;
          addr_d  = {~draw_buf_q, vga_y[8:0], vga_x};
        end
      end
      clr_go: begin
        state_d = WRITE;
        ce_d    = 1'b0;
        we_d    = 1'b0;
        wdata_d = background_data;
        addr_d  = {draw_buf_q, bg_y_q[8:0], bg_x_q};
        if (bg_x_q == HMAX - 10'd1) begin
          bg_x_d = 10'd0;
          if (bg_y_q == VMAX - 10'd1) begin
            bg_y_d     = 10'd0;
            clearing_d = 1'b0;
          end else begin
            bg_y_d = bg_y_q + 10'd1;
          end
        end else begin
          bg_x_d = bg_x_q + 10'd1;
        end
      end
      prog_go: begin
        prog_ack_d = 1'b1;
        if (prog_in) begin
          state_d = WRITE;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          wdata_d = prog_data;
          addr_d  = {draw_buf_q, prog_y[8:0], prog_x};
        end
      end
      default: ;
    endcase
    // swap lands after this edge's grant, which used the old buffer
    if (frame_rise) begin
      draw_buf_d = ~draw_buf_q;
      clearing_d = 1'b1;
      bg_x_d     = 10'd0;
      bg_y_d     = 10'd0;
    end
  end

  always_ff @(posedge sram_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fs1_q       <= 1'b0;
      fs2_q       <= 1'b0;
      fs3_q       <= 1'b0;
      draw_buf_q  <= 1'b0;
      clearing_q  <= 1'b0;
      bg_x_q      <= 10'd0;
      bg_y_q      <= 10'd0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      addr_q      <= 20'd0;
      wdata_q     <= 16'h0000;
      vga_ack_q   <= 1'b0;
      prog_ack_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_oor_q    <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      fs1_q       <= frame_clk;
      fs2_q       <= fs1_q;
      fs3_q       <= fs2_q;
      draw_buf_q  <= draw_buf_d;
      clearing_q  <= clearing_d;
      bg_x_q      <= bg_x_d;
      bg_y_q      <= bg_y_d;
      ce_q        <= ce_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      vga_ack_q   <= vga_ack_d;
      prog_ack_q  <= prog_ack_d;
      rd_pend_q   <= rd_pend_d;
      rd_oor_q    <= rd_oor_d;
      vga_valid_q <= vga_valid_d;
      vga_data_q  <= vga_data_d;
    end
  end

`ifdef SRAM_ARB_OVERRUN_CNT_EN
  logic [15:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (frame_rise && clearing_q && ovr_q != 16'hFFFF)
      ovr_d = ovr_q + 16'd1;
  end

  always_ff @(posedge sram_clk or negedge reset) begin
    if (!reset) ovr_q <= 16'h0000;
    else        ovr_q <= ovr_d;
  end

  assign frame_overrun_cnt = ovr_q;
`else
  assign frame_overrun_cnt = 16'h0000;
`endif

  assign SRAM_DQ   = (state_q == WRITE) ? wdata_q : 16'hzzzz;
  assign SRAM_CE   = ce_q;
  assign SRAM_UB   = ce_q;
  assign SRAM_LB   = ce_q;
  assign SRAM_OE   = oe_q;
  assign SRAM_WE   = we_q;
  assign SRAM_ADDR = addr_q;
  assign vga_ack   = vga_ack_q;
  assign prog_ack  = prog_ack_q;
  assign vga_valid = vga_valid_q;
  assign vga_data  = vga_data_q;
  assign bg_x      = bg_x_q;
  assign bg_y      = bg_y_q;
  assign draw_buf  = draw_buf_q;
  assign clearing  = clearing_q;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed bench for sram_frame_arbiter on a shrunk 8x4 frame.
// SRAM model returns 16'hBEEF on reads; background ROM is a coordinate hash.
module tb_sram_frame_arbiter;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk;
  logic        reset;
  logic        frame_clk;
  logic        vga_req;
  logic [9:0]  vga_x, vga_y;
  logic        vga_ack, vga_valid;
  logic [15:0] vga_data;
  logic        prog_req;
  logic [9:0]  prog_x, prog_y;
  logic [15:0] prog_data;
  logic        prog_ack;
  logic [9:0]  bg_x, bg_y;
  logic [15:0] background_data;
  logic        draw_buf, clearing;
  logic        SRAM_CE, SRAM_UB, SRAM_LB, SRAM_OE, SRAM_WE;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic [15:0] frame_overrun_cnt;

  int nvec = 0;
  int nerr = 0;

  sram_frame_arbiter #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .sram_clk(clk), .reset(reset), .frame_clk(frame_clk),
    .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
    .vga_ack(vga_ack), .vga_valid(vga_valid), .vga_data(vga_data),
    .prog_req(prog_req), .prog_x(prog_x), .prog_y(prog_y),
    .prog_data(prog_data), .prog_ack(prog_ack),
    .bg_x(bg_x), .bg_y(bg_y), .background_data(background_data),
    .draw_buf(draw_buf), .clearing(clearing),
    .SRAM_CE(SRAM_CE), .SRAM_UB(SRAM_UB), .SRAM_LB(SRAM_LB),
    .SRAM_OE(SRAM_OE), .SRAM_WE(SRAM_WE), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ(SRAM_DQ), .frame_overrun_cnt(frame_overrun_cnt)
  );

  function automatic logic [15:0] bgpix(logic [9:0] x, logic [9:0] y);
    return {y[5:0], x} ^ 16'h5A00;
  endfunction

  assign background_data = bgpix(bg_x, bg_y);
  assign SRAM_DQ = (!SRAM_CE && !SRAM_OE && SRAM_WE) ? 16'hBEEF : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  logic [9:0] ex, ey;
  int         nwr;
  logic       saw;
  logic [15:0] exp_ovr;

  initial begin
`ifdef SRAM_ARB_OVERRUN_CNT_EN
    exp_ovr = 16'd1;
`else
    exp_ovr = 16'd0;
`endif
    reset = 1'b0; frame_clk = 1'b0;
    vga_req = 1'b0; vga_x = '0; vga_y = '0;
    prog_req = 1'b0; prog_x = '0; prog_y = '0; prog_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ce", 32'(SRAM_CE), 1);
    chk("rst_we", 32'(SRAM_WE), 1);
    chk("rst_oe", 32'(SRAM_OE), 1);
    chk("rst_addr", 32'(SRAM_ADDR), 0);
    chk("rst_dq_z", 32'(SRAM_DQ === 16'hzzzz), 1);
    chk("rst_acks", {29'd0, vga_ack, prog_ack, vga_valid}, 0);
    chk("rst_buf", {30'd0, draw_buf, clearing}, 0);
    chk("rst_vdata", 32'(vga_data), 0);

    // single read at (3,2) from display buffer 1
    reset = 1'b1;
    vga_req = 1'b1; vga_x = 10'd3; vga_y = 10'd2;
    @(negedge clk);
    chk("rd_ack", 32'(vga_ack), 1);
    chk("rd_addr", 32'(SRAM_ADDR), 32'h80803);
    chk("rd_oe", 32'(SRAM_OE), 0);
    chk("rd_we", 32'(SRAM_WE), 1);
    vga_req = 1'b0;
    @(negedge clk);
    chk("rd_valid", 32'(vga_valid), 1);
    chk("rd_data", 32'(vga_data), 32'hBEEF);
    chk("rd_ack_low", 32'(vga_ack), 0);

    // both requesters held: strict alternation
    vga_req = 1'b1;
    prog_req = 1'b1; prog_x = 10'd5; prog_y = 10'd1; prog_data = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_vga", 32'(vga_ack), 32'(k % 2 == 0));
      chk("alt_prog", 32'(prog_ack), 32'(k % 2 == 1));
      if (k % 2 == 1) begin
        chk("wr_addr", 32'(SRAM_ADDR), 32'h00405);
        chk("wr_dq", 32'(SRAM_DQ), 32'h1234);
        chk("wr_we", 32'(SRAM_WE), 0);
      end
    end
    vga_req = 1'b0; prog_req = 1'b0;
    @(negedge clk);
    chk("idle_ce", 32'(SRAM_CE), 1);
    chk("idle_addr", 32'(SRAM_ADDR), 32'h00405);
    chk("idle_dq_z", 32'(SRAM_DQ === 16'hzzzz), 1);

    // frame edge: swap and full clear of buffer 1
    frame_clk = 1'b1;
    for (int n = 0; n < 20 && !clearing; n++) @(negedge clk);
    chk("clr_start", 32'(clearing), 1);
    chk("clr_buf", 32'(draw_buf), 1);
    prog_req = 1'b1;
    ex = '0; ey = '0; nwr = 0; saw = 1'b0;
    for (int c = 0; c < 200 && nwr < H * V; c++) begin
      if (prog_ack) saw = 1'b1;
      if (!SRAM_WE) begin
        chk("clr_addr", 32'(SRAM_ADDR), 32'({1'b1, ey[8:0], ex}));
        chk("clr_dq", 32'(SRAM_DQ), 32'(bgpix(ex, ey)));
        nwr++;
        if (ex == 10'(H - 1)) begin
          ex = '0;
          ey = ey + 10'd1;
        end else begin
          ex = ex + 10'd1;
        end
      end
      if (nwr < H * V) @(negedge clk);
    end
    chk("clr_words", 32'(nwr), 32'(H * V));
    chk("clr_done", 32'(clearing), 0);
    chk("clr_bg0", {12'd0, bg_x, bg_y}, 0);
    chk("prog_blocked", 32'(saw), 0);
    @(negedge clk);
    chk("post_clr_prog", 32'(prog_ack), 1);
    chk("post_clr_addr", 32'(SRAM_ADDR), 32'h80405);
    prog_req = 1'b0; frame_clk = 1'b0;
    @(negedge clk);

    // out-of-range on both sides
    prog_x = 10'(H); prog_y = 10'd0; prog_req = 1'b1;
    vga_x = 10'd0; vga_y = 10'(V); vga_req = 1'b1;
    @(negedge clk);
    chk("oor_vack", 32'(vga_ack), 1);
    chk("oor_rd_ce", {29'd0, SRAM_CE, SRAM_OE, SRAM_WE}, 32'h7);
    vga_req = 1'b0;
    @(negedge clk);
    chk("oor_pack", 32'(prog_ack), 1);
    chk("oor_valid", 32'(vga_valid), 1);
    chk("oor_vdata", 32'(vga_data), 0);
    chk("oor_wr_ce", {29'd0, SRAM_CE, SRAM_OE, SRAM_WE}, 32'h7);
    chk("oor_dq_z", 32'(SRAM_DQ === 16'hzzzz), 1);
    prog_req = 1'b0;

    // overrun: second frame edge while clearing
    frame_clk = 1'b1;
    for (int n = 0; n < 20 && !clearing; n++) @(negedge clk);
    chk("ovr_clr", 32'(clearing), 1);
    chk("ovr_buf0", 32'(draw_buf), 0);
    repeat (3) @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    frame_clk = 1'b1;
    for (int n = 0; n < 20 && !draw_buf; n++) @(negedge clk);
    chk("ovr_buf1", 32'(draw_buf), 1);
    chk("ovr_bg0", {12'd0, bg_x, bg_y}, 0);
    chk("ovr_still", 32'(clearing), 1);
    chk("ovr_cnt", 32'(frame_overrun_cnt), 32'(exp_ovr));

    // reset in the middle of a clear write
    @(negedge clk);
    chk("pre_rst_we", 32'(SRAM_WE), 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", 32'(SRAM_WE), 1);
    chk("mid_rst_ce", 32'(SRAM_CE), 1);
    chk("mid_rst_dq", 32'(SRAM_DQ === 16'hzzzz), 1);
    chk("mid_rst_st", {30'd0, clearing, draw_buf}, 0);
    chk("mid_rst_cnt", 32'(frame_overrun_cnt), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_resume", {30'd0, clearing, SRAM_CE}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
